// File: rtl/input_hub_pkg.sv
// input_hub_pkg: shared types and default constants for the player click front end.
package input_hub_pkg;

  // Ready-consensus FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } hub_state_e;

  // Defaults sized for the 65 MHz pixel clock (~10 ms hold-off, ~1 ms debounce)
  localparam int HOLDOFF_DEFAULT  = 650000;
  localparam int DEBOUNCE_DEFAULT = 65000;
  localparam int MAX_PLAYERS      = 8;

  // Counter width able to hold 0..max_val; never narrower than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_channel.sv
// input_channel: one click source -- synchroniser, optional debounce, rise detect, hold-off.
// Optional: define INPUT_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable samples before the
// synchronised level is believed.
module input_channel
  import input_hub_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
`ifdef INPUT_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in_async,
  output logic level,
  output logic accepted,
  output logic dropped
);

  localparam int HW = cnt_width(HOLDOFF_CYCLES);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic                   prev_reg;
  logic                   rise;
  logic [HW-1:0]          holdoff_cnt_reg;
  logic                   dropped_reg;

  // Metastability chain: shift the raw level through SYNC_STAGES flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_async};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

`ifdef INPUT_DEBOUNCE_EN
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);

  logic [DW-1:0] deb_cnt_reg;
  logic          stable_reg;

  // Debounce: adopt a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_reg <= '0;
      stable_reg  <= 1'b0;
    end else if (sync_out == stable_reg) begin
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg >= DW'(DEBOUNCE_CYCLES - 1)) begin
      deb_cnt_reg <= '0;
      stable_reg  <= sync_out;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end

  assign level = stable_reg;
`else
  assign level = sync_out;
`endif

  // A rise is only accepted once the previous click's hold-off window has run out
  assign rise     = level & ~prev_reg;
  assign accepted = rise && (holdoff_cnt_reg == '0);
  assign dropped  = dropped_reg;

  // Edge history, hold-off countdown (saturates at 0) and the dropped-rise pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg        <= 1'b0;
      holdoff_cnt_reg <= '0;
      dropped_reg     <= 1'b0;
    end else begin
      prev_reg    <= level;
      dropped_reg <= rise && (holdoff_cnt_reg != '0);
      if (accepted) begin
        holdoff_cnt_reg <= HW'(HOLDOFF_CYCLES);
      end else if (holdoff_cnt_reg != '0) begin
        holdoff_cnt_reg <= holdoff_cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_input_hub.sv
// player_input_hub: N-channel click front end feeding game_fsm, plus ready-consensus FSM.
// Optional: define INPUT_DEBOUNCE_EN to debounce every channel (adds DEBOUNCE_CYCLES latency).
module player_input_hub
  import input_hub_pkg::*;
#(
  parameter int N_PLAYERS      = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
`ifdef INPUT_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] in_async,
  input  logic                 enable,
  input  logic                 arm,
  output logic [N_PLAYERS-1:0] click_pulse,
  output logic [N_PLAYERS-1:0] click_level,
  output logic [N_PLAYERS-1:0] dropped,
  output logic [N_PLAYERS-1:0] ready_mask,
  output logic                 all_ready
);

  logic [N_PLAYERS-1:0] accepted;
  logic [N_PLAYERS-1:0] click_pulse_reg;
  logic [N_PLAYERS-1:0] ready_mask_reg;
  logic [N_PLAYERS-1:0] ready_mask_next;
  hub_state_e           state_reg;
  hub_state_e           state_next;

  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_channel
    input_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
`ifdef INPUT_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .in_async(in_async[gi]),
      .level   (click_level[gi]),
      .accepted(accepted[gi]),
      .dropped (dropped[gi])
    );
  end

  // Game-facing pulses: accepted clicks are forwarded only while the game runs, never queued
  always_ff @(posedge clk) begin
    if (rst) begin
      click_pulse_reg <= '0;
    end else begin
      click_pulse_reg <= accepted & {N_PLAYERS{enable}};
    end
  end

  assign click_pulse = click_pulse_reg;
  assign ready_mask  = ready_mask_reg;

  // FSM state and ready mask registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ready_mask_reg <= '0;
    end else begin
      state_reg      <= state_next;
      ready_mask_reg <= ready_mask_next;
    end
  end

  // Consensus: arm restarts collection (same-cycle clicks count); full mask gives one DONE cycle
  always_comb begin
    state_next      = state_reg;
    ready_mask_next = ready_mask_reg;
    all_ready       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next      = COLLECT;
          ready_mask_next = accepted;
        end
      end
      COLLECT: begin
        if (arm) begin
          ready_mask_next = accepted;
        end else begin
          ready_mask_next = ready_mask_reg | accepted;
          if (ready_mask_reg == '1) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        all_ready  = 1'b1;
        state_next = IDLE;
        if (arm) begin
          state_next      = COLLECT;
          ready_mask_next = accepted;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_player_input_hub.sv
// tb_player_input_hub: directed self-checking bench for player_input_hub (3 players).
// Build with INPUT_DEBOUNCE_EN defined to exercise the debounce configuration.
module tb_player_input_hub;

  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int HOLD = 8;
`ifdef INPUT_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int H   = 4;   // segment length for the hold-off waveform
  localparam int R1  = 8;
  localparam int R2  = 16;
`else
  localparam int DEB = 0;
  localparam int H   = 2;
  localparam int R1  = 6;
  localparam int R2  = 10;
`endif
  localparam int LAT    = SYNC + DEB + 1;
  localparam int SETTLE = HOLD + DEB + SYNC + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_async;
  logic         enable;
  logic         arm;
  logic [N-1:0] click_pulse;
  logic [N-1:0] click_level;
  logic [N-1:0] dropped;
  logic [N-1:0] ready_mask;
  logic         all_ready;

  int checks = 0;
  int errors = 0;

  player_input_hub #(
    .N_PLAYERS     (N),
    .SYNC_STAGES   (SYNC),
    .HOLDOFF_CYCLES(HOLD)
`ifdef INPUT_DEBOUNCE_EN
    ,
    .DEBOUNCE_CYCLES(DEB)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_async   (in_async),
    .enable     (enable),
    .arm        (arm),
    .click_pulse(click_pulse),
    .click_level(click_level),
    .dropped    (dropped),
    .ready_mask (ready_mask),
    .all_ready  (all_ready)
  );

  always #5 clk = ~clk;

  // Advance one cycle; drive and sample 1 ns after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_in(input int ch);
    in_async[ch] = 1'b1;
    repeat (LAT) step();
  endtask

  task automatic release_in(input int ch);
    in_async[ch] = 1'b0;
    repeat (SETTLE) step();
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_async = '0; enable = 1'b0; arm = 1'b0;
    repeat (3) step();
    checks++; if (click_pulse !== 3'b000) begin errors++; $display("FAIL reset_click_pulse got %b expected 000", click_pulse); end
    checks++; if (click_level !== 3'b000) begin errors++; $display("FAIL reset_click_level got %b expected 000", click_level); end
    checks++; if (dropped !== 3'b000) begin errors++; $display("FAIL reset_dropped got %b expected 000", dropped); end
    checks++; if (ready_mask !== 3'b000) begin errors++; $display("FAIL reset_ready_mask got %b expected 000", ready_mask); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL reset_all_ready got %b expected 0", all_ready); end
    rst = 1'b0;
    $display("test_reset: outputs checked during reset");
  endtask

  task automatic test_latency();
    logic [N-1:0] exp;
    enable = 1'b1;
    repeat (10) step();
    in_async[0] = 1'b1;   // held high: exactly one pulse, even after hold-off expires
    for (int k = 0; k <= LAT + HOLD + 4; k++) begin
      exp = (k == LAT) ? 3'b001 : 3'b000;
      checks++; if (click_pulse !== exp) begin errors++; $display("FAIL latency_pulse k=%0d got %b expected %b", k, click_pulse, exp); end
      step();
    end
    checks++; if (ready_mask !== 3'b000) begin errors++; $display("FAIL idle_mask_unchanged got %b expected 000", ready_mask); end
    release_in(0);
    $display("test_latency: ch0 rise, pulse expected at cycle %0d", LAT);
  endtask

  task automatic test_holdoff();
    logic ep, ed;
    for (int t = 0; t <= R2 + LAT + 2; t++) begin
      in_async[0] = (t < H) || (t >= R1 && t < R1 + H) || (t >= R2 && t < R2 + H);
      ep = (t == LAT) || (t == R2 + LAT);
      ed = (t == R1 + LAT);
      checks++; if (click_pulse[0] !== ep) begin errors++; $display("FAIL holdoff_pulse t=%0d got %b expected %b", t, click_pulse[0], ep); end
      checks++; if (dropped[0] !== ed) begin errors++; $display("FAIL holdoff_dropped t=%0d got %b expected %b", t, dropped[0], ed); end
      step();
    end
    release_in(0);
    $display("test_holdoff: rises at 0, %0d (dropped), %0d (accepted)", R1, R2);
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    arm_pulse();
    in_async[1] = 1'b1;
    for (int k = 0; k <= LAT + 1; k++) begin
      checks++; if (click_pulse !== 3'b000) begin errors++; $display("FAIL enoff_pulse k=%0d got %b expected 000", k, click_pulse); end
      if (k >= LAT - 1) begin
        checks++; if (click_level[1] !== 1'b1) begin errors++; $display("FAIL enoff_level k=%0d got %b expected 1", k, click_level[1]); end
      end
      step();
    end
    checks++; if (ready_mask !== 3'b010) begin errors++; $display("FAIL enoff_mask got %b expected 010", ready_mask); end
    release_in(1);
    $display("test_enable_off: ch1 click with enable low");
  endtask

  task automatic test_consensus();
    enable = 1'b1;
    arm_pulse();
    checks++; if (ready_mask !== 3'b000) begin errors++; $display("FAIL cons_arm_clear got %b expected 000", ready_mask); end
    pulse_in(0);
    checks++; if (ready_mask !== 3'b001) begin errors++; $display("FAIL cons_mask_ch0 got %b expected 001", ready_mask); end
    checks++; if (click_pulse !== 3'b001) begin errors++; $display("FAIL cons_pulse_ch0 got %b expected 001", click_pulse); end
    release_in(0);
    pulse_in(2);
    checks++; if (ready_mask !== 3'b101) begin errors++; $display("FAIL cons_mask_ch2 got %b expected 101", ready_mask); end
    release_in(2);
    pulse_in(1);
    checks++; if (ready_mask !== 3'b111) begin errors++; $display("FAIL cons_mask_ch1 got %b expected 111", ready_mask); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL cons_ready_early got %b expected 0", all_ready); end
    step();
    checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL cons_all_ready got %b expected 1", all_ready); end
    step();
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL cons_ready_one_cycle got %b expected 0", all_ready); end
    release_in(1);
    pulse_in(0);   // back in IDLE: mask holds, no further all_ready
    checks++; if (ready_mask !== 3'b111) begin errors++; $display("FAIL cons_idle_hold got %b expected 111", ready_mask); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL cons_idle_ready got %b expected 0", all_ready); end
    release_in(0);
    $display("test_consensus: ch0, ch2, ch1 then all_ready");
  endtask

  task automatic test_arm_restart();
    in_async[2] = 1'b1;
    repeat (LAT - 1) step();
    arm_pulse();   // arm coincides with the ch2 accept
    checks++; if (ready_mask !== 3'b100) begin errors++; $display("FAIL arm_same_cycle got %b expected 100", ready_mask); end
    release_in(2);
    arm_pulse();
    checks++; if (ready_mask !== 3'b000) begin errors++; $display("FAIL arm_clear got %b expected 000", ready_mask); end
    pulse_in(0);
    release_in(0);
    pulse_in(1);
    checks++; if (ready_mask !== 3'b011) begin errors++; $display("FAIL arm_mask_011 got %b expected 011", ready_mask); end
    release_in(1);
    arm_pulse();
    checks++; if (ready_mask !== 3'b000) begin errors++; $display("FAIL arm_mid_collect got %b expected 000", ready_mask); end
    $display("test_arm_restart: same-cycle arm and mid-collect restart");
  endtask

  task automatic test_glitch_and_reset();
    logic ep;
    in_async[0] = 1'b1;
    for (int k = 0; k <= LAT + 4; k++) begin
      if (k == 2) in_async[0] = 1'b0;
      ep = (DEB == 0) && (k == LAT);
      checks++; if (click_pulse[0] !== ep) begin errors++; $display("FAIL glitch_pulse k=%0d got %b expected %b", k, click_pulse[0], ep); end
      step();
    end
    repeat (SETTLE) step();
    in_async[0] = 1'b1;
    for (int k = 0; k <= LAT + 4; k++) begin
      if (k == 6) in_async[0] = 1'b0;
      ep = (k == LAT);
      checks++; if (click_pulse[0] !== ep) begin errors++; $display("FAIL wide_pulse k=%0d got %b expected %b", k, click_pulse[0], ep); end
      step();
    end
    repeat (SETTLE) step();
    pulse_in(0);   // hold-off now running
    checks++; if (click_pulse !== 3'b001) begin errors++; $display("FAIL prereset_pulse got %b expected 001", click_pulse); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (click_pulse !== 3'b000) begin errors++; $display("FAIL midrst_pulse got %b expected 000", click_pulse); end
    checks++; if (click_level !== 3'b000) begin errors++; $display("FAIL midrst_level got %b expected 000", click_level); end
    checks++; if (ready_mask !== 3'b000) begin errors++; $display("FAIL midrst_mask got %b expected 000", ready_mask); end
    checks++; if (dropped !== 3'b000) begin errors++; $display("FAIL midrst_dropped got %b expected 000", dropped); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL midrst_all_ready got %b expected 0", all_ready); end
    for (int k = 0; k <= LAT + 1; k++) begin   // counter cleared: still-high input accepted again
      ep = (k == LAT);
      checks++; if (click_pulse[0] !== ep) begin errors++; $display("FAIL postrst_pulse k=%0d got %b expected %b", k, click_pulse[0], ep); end
      checks++; if (dropped[0] !== 1'b0) begin errors++; $display("FAIL postrst_dropped k=%0d got %b expected 0", k, dropped[0]); end
      step();
    end
    checks++; if (ready_mask !== 3'b000) begin errors++; $display("FAIL postrst_mask got %b expected 000", ready_mask); end
    release_in(0);
    $display("test_glitch_and_reset: debounce=%0d glitch, wide pulse, reset mid hold-off", DEB);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_holdoff();
    test_enable_off();
    test_consensus();
    test_arm_restart();
    test_glitch_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the stimulus is fixed-length, so this should never fire
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
